// File: rtl/parking_pkg.sv
// Shared parking-lot constants and sizing helpers used by the conditioner and display blocks.
// Occupancy encoding: 1 = occupied, 0 = free (same meaning on every slot vector in the lot).
// Helpers: bits_for() sizes counters for 0..max_val, cnt_w() sizes the occupied-slot count.
package parking_pkg;

    localparam int NUM_SLOTS_DEF      = 5;
    localparam int TICK_DIV_DEF       = 100000;   // 1 kHz sample tick at 100 MHz
    localparam int DEBOUNCE_TICKS_DEF = 20;

    localparam logic SLOT_FREE     = 1'b0;
    localparam logic SLOT_OCCUPIED = 1'b1;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int bits_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of a population count over num_slots bits.
    function automatic int cnt_w(input int num_slots);
        return bits_for(num_slots);
    endfunction

endpackage

// File: rtl/slot_sensor_conditioner_if.sv
// Occupancy bus between the raw sensor inputs, the conditioner and the display logic.
// master = conditioner (consumes raw_sensors, produces the clean occupancy view).
// slave  = sensor/display side (drives raw_sensors, consumes everything else).
interface slot_sensor_conditioner_if #(
    parameter int NUM_SLOTS = parking_pkg::NUM_SLOTS_DEF
);
    import parking_pkg::*;

    localparam int CNT_W = cnt_w(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] raw_sensors;
    logic [NUM_SLOTS-1:0] parking_slots;
    logic [NUM_SLOTS-1:0] arrive_pulse;
    logic [NUM_SLOTS-1:0] depart_pulse;
    logic [CNT_W-1:0]     occupied_count;
    logic                 lot_full;

    modport master (
        input  raw_sensors,
        output parking_slots, arrive_pulse, depart_pulse, occupied_count, lot_full
    );

    modport slave (
        output raw_sensors,
        input  parking_slots, arrive_pulse, depart_pulse, occupied_count, lot_full
    );

endinterface

// File: rtl/slot_debounce.sv
// One-slot sensor conditioner: 2-flop synchronizer, tick-based debounce counter, stable bit S.
// Ports: clock/reset, tick (one-cycle sample strobe), raw (async sensor); stable (S), stable_nxt
// (value S takes on the next edge), rise/fall (registered, high in the first cycle S shows the flip).
module slot_debounce #(
    parameter int DEBOUNCE_TICKS = parking_pkg::DEBOUNCE_TICKS_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic stable_nxt,
    output logic rise,
    output logic fall
);
    import parking_pkg::*;

    localparam int              DB_W    = bits_for(DEBOUNCE_TICKS - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]      sync_q;    // sync_q[1] is the synchronized sensor value
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            flip;

    // Any cycle where the synchronized input agrees with S wipes the count, so a
    // single-cycle return to the stable level discards all progress.
    always_comb begin
        stable_nxt = stable;
        cnt_d      = cnt_q;
        flip       = 1'b0;
        if (sync_q[1] == stable) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == DB_LAST) begin
                stable_nxt = ~stable;
                cnt_d      = '0;
                flip       = 1'b1;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            stable <= SLOT_FREE;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            cnt_q  <= cnt_d;
            stable <= stable_nxt;
            rise   <= flip && (stable_nxt == SLOT_OCCUPIED);
            fall   <= flip && (stable_nxt == SLOT_FREE);
        end
    end

endmodule

// File: rtl/slot_sensor_conditioner.sv
// Turns raw, bouncy per-slot occupancy sensors into a clean clock-synchronous parking_slots vector.
// Ports: clock, reset (sync, active-high), bus (master): raw_sensors in; parking_slots,
// arrive_pulse, depart_pulse, occupied_count, lot_full out. Count/full register with S (no lag).
module slot_sensor_conditioner #(
    parameter int NUM_SLOTS      = parking_pkg::NUM_SLOTS_DEF,
    parameter int TICK_DIV       = parking_pkg::TICK_DIV_DEF,
    parameter int DEBOUNCE_TICKS = parking_pkg::DEBOUNCE_TICKS_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    slot_sensor_conditioner_if.master  bus
);
    import parking_pkg::*;

    localparam int               CNT_W    = cnt_w(NUM_SLOTS);
    localparam int               PRE_W    = bits_for(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]     presc_q;
    logic                 tick;
    logic [NUM_SLOTS-1:0] stable;
    logic [NUM_SLOTS-1:0] stable_nxt;
    logic [NUM_SLOTS-1:0] rise;
    logic [NUM_SLOTS-1:0] fall;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     count_q;
    logic                 full_q;

    // Free-running sample prescaler; independent of sensor activity.
    assign tick = (presc_q == PRE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_debounce #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_debounce (
            .clock      (clock),
            .reset      (reset),
            .tick       (tick),
            .raw        (bus.raw_sensors[i]),
            .stable     (stable[i]),
            .stable_nxt (stable_nxt[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );
    end

    // Count and full flag are derived from the next S values so they land on the
    // same edge as parking_slots and always agree with it.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_d = count_d + CNT_W'(stable_nxt[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= &stable_nxt;
        end
    end

    assign bus.parking_slots  = stable;
    assign bus.arrive_pulse   = rise;
    assign bus.depart_pulse   = fall;
    assign bus.occupied_count = count_q;
    assign bus.lot_full       = full_q;

endmodule

// File: tb/tb_slot_sensor_conditioner.sv
// Bench for slot_sensor_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3.
// Expected slot events are queued when the sensors are driven and popped when a pulse appears.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_slot_sensor_conditioner;

    localparam int N  = 5;
    localparam int CW = 3;

    typedef struct packed {
        logic [N-1:0]  arrive;
        logic [N-1:0]  depart;
        logic [N-1:0]  slots;
        logic [CW-1:0] count;
        logic          full;
    } obs_t;

    typedef struct {
        obs_t val;
        int   lo;
        int   hi;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    slot_sensor_conditioner_if #(.NUM_SLOTS(N)) bus ();

    slot_sensor_conditioner #(
        .NUM_SLOTS      (N),
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clock) cyc <= cyc + 1;

    exp_t         exp_q[$];
    logic [N-1:0] model_slots = '0;

    function automatic obs_t observe();
        return {bus.arrive_pulse, bus.depart_pulse, bus.parking_slots,
                bus.occupied_count, bus.lot_full};
    endfunction

    // Expected outputs in the cycle the debounced vector moves from old_s to new_s.
    function automatic obs_t predict(input logic [N-1:0] old_s, input logic [N-1:0] new_s);
        obs_t o;
        o.arrive = new_s & ~old_s;
        o.depart = old_s & ~new_s;
        o.slots  = new_s;
        o.count  = CW'($countones(new_s));
        o.full   = (new_s == {N{1'b1}});
        return o;
    endfunction

    function automatic obs_t quiet(input obs_t o);
        obs_t q;
        q        = o;
        q.arrive = '0;
        q.depart = '0;
        return q;
    endfunction

    // Waits on falling edges until any pulse shows or the budget since start expires.
    task automatic wait_pulse(input int start, input int limit, output bit seen, output obs_t prev);
        seen = 1'b0;
        prev = observe();
        while (!seen && (cyc - start) < limit) begin
            @(negedge clock);
            if ((bus.arrive_pulse | bus.depart_pulse) != '0) seen = 1'b1;
            else prev = observe();
        end
    endtask

    task automatic test_reset();
        bit   seen;
        obs_t prev;
        exp_t e;
        int   start;
        reset = 1'b1;
        bus.raw_sensors = 5'b11111;
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (observe() !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got %b, required all zero", observe());
            end
        end
        reset = 1'b0;
        start = cyc;
        model_slots = '0;
        exp_q.push_back('{predict(model_slots, 5'b11111), 11, 14});
        @(negedge clock);
        vectors++;
        if (observe() !== '0) begin
            miscompares++;
            $display("FAIL reset_first_cycle: got %b, required all zero", observe());
        end
        wait_pulse(start, 16, seen, prev);
        e = exp_q.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_arrive_timeout: no pulse by cycle %0d, required %0d..%0d", cyc - start, e.lo, e.hi);
        end else begin
            if ((cyc - start) < e.lo || (cyc - start) > e.hi) begin
                miscompares++;
                $display("FAIL reset_arrive_latency: got %0d cycles, required %0d..%0d", cyc - start, e.lo, e.hi);
            end
            vectors++;
            if (observe() !== e.val) begin
                miscompares++;
                $display("FAIL reset_arrive_value: got %b, required %b", observe(), e.val);
            end
            @(negedge clock);
            vectors++;
            if (observe() !== quiet(e.val)) begin
                miscompares++;
                $display("FAIL reset_arrive_width: got %b, required %b", observe(), quiet(e.val));
            end
        end
        model_slots = e.val.slots;
    endtask

    // Drives a new raw vector and checks the resulting single debounced event.
    task automatic test_event(input string name, input logic [N-1:0] raw_new, input int lo);
        bit   seen;
        obs_t prev;
        exp_t e;
        int   start;
        bus.raw_sensors = raw_new;
        start = cyc;
        exp_q.push_back('{predict(model_slots, raw_new), lo, 14});
        wait_pulse(start, 16, seen, prev);
        e = exp_q.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_timeout: no pulse by cycle %0d, required %0d..%0d", name, cyc - start, e.lo, e.hi);
        end else begin
            if ((cyc - start) < e.lo || (cyc - start) > e.hi) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d cycles, required %0d..%0d", name, cyc - start, e.lo, e.hi);
            end
            vectors++;
            if (prev !== predict(model_slots, model_slots)) begin
                miscompares++;
                $display("FAIL %s_before: got %b, required %b", name, prev, predict(model_slots, model_slots));
            end
            vectors++;
            if (observe() !== e.val) begin
                miscompares++;
                $display("FAIL %s_value: got %b, required %b", name, observe(), e.val);
            end
            @(negedge clock);
            vectors++;
            if (observe() !== quiet(e.val)) begin
                miscompares++;
                $display("FAIL %s_width: got %b, required %b", name, observe(), quiet(e.val));
            end
        end
        model_slots = e.val.slots;
    endtask

    task automatic test_glitch();
        int hits = 0;
        @(negedge clock);
        bus.raw_sensors[0] = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if ((bus.arrive_pulse | bus.depart_pulse) != '0) hits++;
        end
        bus.raw_sensors[0] = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if ((bus.arrive_pulse | bus.depart_pulse) != '0) hits++;
        end
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("FAIL glitch_pulses: got %0d pulse cycles, required 0", hits);
        end
        vectors++;
        if (observe() !== predict(model_slots, model_slots)) begin
            miscompares++;
            $display("FAIL glitch_state: got %b, required %b", observe(), predict(model_slots, model_slots));
        end
    endtask

    task automatic test_bounce();
        int hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k % 3 == 0) bus.raw_sensors[1] = ~bus.raw_sensors[1];
            if ((bus.arrive_pulse | bus.depart_pulse) != '0) hits++;
        end
        vectors++;
        if (hits !== 0 || bus.parking_slots !== model_slots) begin
            miscompares++;
            $display("FAIL bounce_quiet: got %0d pulse cycles slots %b, required 0 and %b", hits, bus.parking_slots, model_slots);
        end
        test_event("bounce_hold", model_slots | 5'b00010, 1);
    endtask

    task automatic test_reset_mid_debounce();
        bit   seen;
        obs_t prev;
        exp_t e;
        int   start;
        int   hits = 0;
        bus.raw_sensors[3] = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if ((bus.arrive_pulse | bus.depart_pulse) != '0) hits++;
        end
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("FAIL midreset_early_pulse: got %0d pulse cycles, required 0", hits);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (observe() !== '0) begin
            miscompares++;
            $display("FAIL midreset_cleared: got %b, required all zero", observe());
        end
        start = cyc;
        model_slots = '0;
        exp_q.push_back('{predict(model_slots, bus.raw_sensors), 11, 14});
        wait_pulse(start, 16, seen, prev);
        e = exp_q.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midreset_timeout: no pulse by cycle %0d, required %0d..%0d", cyc - start, e.lo, e.hi);
        end else begin
            if ((cyc - start) < e.lo || (cyc - start) > e.hi) begin
                miscompares++;
                $display("FAIL midreset_latency: got %0d cycles, required %0d..%0d", cyc - start, e.lo, e.hi);
            end
            vectors++;
            if (observe() !== e.val) begin
                miscompares++;
                $display("FAIL midreset_value: got %b, required %b", observe(), e.val);
            end
        end
        model_slots = e.val.slots;
    endtask

    initial begin
        bus.raw_sensors = '0;
        test_reset();
        test_event("simul_depart", 5'b01110, 11);
        test_event("clear", 5'b00000, 11);
        test_event("clean_arrival", 5'b00100, 11);
        test_glitch();
        test_bounce();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
